// File: rtl/wave_pkg.sv
// Shared waveform definitions: crossing-detector FSM states and the default
// midpoint/hysteresis used by the voice-path generators and analysers.
package wave_pkg;

  typedef enum logic {
    WAIT_LOW  = 1'b0,
    WAIT_HIGH = 1'b1
  } wave_state_t;

  localparam int unsigned DEFAULT_MID  = 128;
  localparam int unsigned DEFAULT_HYST = 16;

endpackage

// File: rtl/wave_hyst_cmp.sv
// Hysteresis comparator: arms once the sample drops below lo_th, then flags a
// rising crossing on the first enabled sample above hi_th.
module wave_hyst_cmp
  import wave_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sample,
  input  logic       sample_en,
  input  logic [7:0] hi_th,
  input  logic [7:0] lo_th,
  input  logic       rearm,
  output logic       crossing
);

  wave_state_t state;

  // Decoded from the registered state so the caller sees the crossing in the
  // same cycle the qualifying sample is presented.
  assign crossing = sample_en && (state == WAIT_HIGH) && (sample > hi_th);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= WAIT_LOW;
    end else if (sample_en) begin
      if (rearm) begin
        state <= WAIT_LOW;
      end else begin
        case (state)
          WAIT_LOW:  if (sample < lo_th) state <= WAIT_HIGH;
          WAIT_HIGH: if (sample > hi_th) state <= WAIT_LOW;
          default:   state <= WAIT_LOW;
        endcase
      end
    end
  end

endmodule

// File: rtl/wave_period_detector.sv
// Period detector: counts enabled samples between hysteresis-qualified rising
// crossings and reports period, lock and timeout. Define WAVE_PERIOD_AVG_EN to
// report the mean of the last four raw measurements instead of the raw value.
module wave_period_detector
  import wave_pkg::*;
#(
  parameter int unsigned MID        = DEFAULT_MID,
  parameter int unsigned HYST       = DEFAULT_HYST,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned TIMEOUT    = 1 << 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       sample,
  input  logic             sample_en,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [7:0]       HI_TH = 8'(MID + HYST);
  localparam logic [7:0]       LO_TH = 8'(MID - HYST);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  logic             crossing;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             have_ref;
  logic             have_prev;
  logic [CNT_W-1:0] prev_raw;
  logic [CNT_W:0]   cur_ext;
  logic [CNT_W:0]   prev_ext;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   tol;
  logic             lock_ok;

  wave_hyst_cmp u_cmp (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample    (sample),
    .sample_en (sample_en),
    .hi_th     (HI_TH),
    .lo_th     (LO_TH),
    .rearm     (tmo_hit),
    .crossing  (crossing)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;
  // A crossing in the same cycle always pre-empts the timeout.
  assign tmo_hit = sample_en && have_ref && !crossing && (cnt >= TMO_C);

  // Lock compares raw measurements one bit wider so the difference cannot wrap.
  assign cur_ext  = {1'b0, cnt};
  assign prev_ext = {1'b0, prev_raw};
  assign diff     = (cur_ext >= prev_ext) ? (cur_ext - prev_ext) : (prev_ext - cur_ext);
  assign tol      = prev_ext >> 3;
  assign lock_ok  = have_prev && (diff <= tol);

`ifdef WAVE_PERIOD_AVG_EN
  logic [CNT_W-1:0] hist [4];
  logic [CNT_W+1:0] hist_sum;
  logic [CNT_W+1:0] sum_next;
  logic [2:0]       hist_fill;

  assign sum_next = hist_sum - {2'b00, hist[3]} + {2'b00, cnt};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      have_ref     <= 1'b0;
      have_prev    <= 1'b0;
      prev_raw     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
`ifdef WAVE_PERIOD_AVG_EN
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      hist_sum  <= '0;
      hist_fill <= '0;
`endif
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (sample_en) begin
        if (crossing) begin
          if (!have_ref) begin
            have_ref <= 1'b1;
            cnt      <= ONE;
          end else if (cnt >= MIN_P) begin
            cnt       <= ONE;
            prev_raw  <= cnt;
            have_prev <= 1'b1;
            locked    <= lock_ok;
`ifdef WAVE_PERIOD_AVG_EN
            hist[0] <= cnt;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            hist_sum <= sum_next;
            if (hist_fill != 3'd4) hist_fill <= hist_fill + 3'd1;
            if (hist_fill >= 3'd3) begin
              period       <= CNT_W'(sum_next >> 2);
              period_valid <= 1'b1;
            end
`else
            period       <= cnt;
            period_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end else if (have_ref) begin
          if (tmo_hit) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            have_ref  <= 1'b0;
            have_prev <= 1'b0;
            cnt       <= '0;
`ifdef WAVE_PERIOD_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            hist_sum  <= '0;
            hist_fill <= '0;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_period_detector.sv
// Directed bench for wave_period_detector: stepped triangles, glitches,
// timeouts, period changes and mid-stream reset.
module tb_wave_period_detector;

`ifdef WAVE_PERIOD_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  sample;
  logic        sample_en;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int q_per[$];
  bit q_lck[$];
  int q_cyc[$];
  logic [7:0] lv [8];

  wave_period_detector #(.TIMEOUT(1000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .sample_en    (sample_en),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (period_valid) begin
      q_per.push_back(int'(period));
      q_lck.push_back(locked);
      q_cyc.push_back(cyc);
      $display("strobe cyc=%0d period=%0d locked=%0d", cyc, period, locked);
    end
    if (timeout) $display("timeout cyc=%0d", cyc);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [7:0] s, input logic en);
    sample    = s;
    sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_per.delete();
    q_lck.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(8'd100, 1'b0);
    reset_n = 1'b1;
    clear_q();
  endtask

  // Triangle cycle starts at the first 192 so each crossing begins a cycle.
  task automatic drive_tri(input int hold, input int ncyc, input bit half_rate);
    for (int c = 0; c < ncyc; c++)
      for (int l = 0; l < 8; l++)
        for (int h = 0; h < hold; h++) begin
          step(lv[l], 1'b1);
          if (half_rate) step(lv[l], 1'b0);
        end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(8'd200, 1'b1);
    step(8'd50, 1'b1);
    checks++; if (period !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", period_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
    reset_n = 1'b1;
    clear_q();
  endtask

  task automatic test_triangle();
    int exp_n;
    do_reset();
    drive_tri(10, 7, 1'b0);
    exp_n = AVG ? 2 : 5;
    checks++; if (q_per.size() != exp_n) begin errors++; $display("FAIL tri_count: got %0d expected %0d", q_per.size(), exp_n); end
    for (int i = 0; i < q_per.size(); i++) begin
      checks++; if (q_per[i] != 80) begin errors++; $display("FAIL tri_period[%0d]: got %0d expected 80", i, q_per[i]); end
      checks++; if (q_lck[i] != ((i == 0) ? AVG : 1'b1)) begin errors++; $display("FAIL tri_locked[%0d]: got %0b expected %0b", i, q_lck[i], (i == 0) ? AVG : 1'b1); end
    end
  endtask

  task automatic test_half_rate();
    int exp_n;
    do_reset();
    drive_tri(10, 7, 1'b1);
    exp_n = AVG ? 2 : 5;
    checks++; if (q_per.size() != exp_n) begin errors++; $display("FAIL half_count: got %0d expected %0d", q_per.size(), exp_n); end
    for (int i = 0; i < q_per.size(); i++) begin
      checks++; if (q_per[i] != 80) begin errors++; $display("FAIL half_period[%0d]: got %0d expected 80", i, q_per[i]); end
      if (i > 0) begin
        checks++; if (q_cyc[i] - q_cyc[i-1] != 160) begin errors++; $display("FAIL half_spacing[%0d]: got %0d expected 160", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_square();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int h = 0; h < 10; h++) step(8'd120, 1'b1);
      for (int h = 0; h < 10; h++) step(8'd150, 1'b1);
    end
    for (int p = 0; p < 5; p++) begin
      for (int h = 0; h < 10; h++) step(8'd100, 1'b1);
      for (int h = 0; h < 10; h++) step(8'd140, 1'b1);
    end
    checks++; if (q_per.size() != 0) begin errors++; $display("FAIL square_strobes: got %0d expected 0", q_per.size()); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL square_locked: got %0b expected 0", locked); end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 3; i++) step(8'd64, 1'b1);
    step(8'd200, 1'b1);
    step(8'd64, 1'b1);
    step(8'd200, 1'b1);
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL glitch_discard: got %0b expected 0", period_valid); end
    for (int i = 0; i < 5; i++) step(8'd64, 1'b1);
    step(8'd200, 1'b1);
    checks++; if (period_valid !== !AVG) begin errors++; $display("FAIL glitch_strobe: got %0b expected %0b", period_valid, !AVG); end
    if (!AVG) begin
      checks++; if (period !== 32'd8) begin errors++; $display("FAIL glitch_period: got %0d expected 8", period); end
    end
  endtask

  task automatic test_spike_timeout();
    int n_tmo = 0;
    int first_tmo = 0;
    do_reset();
    for (int i = 0; i < 5; i++) step(8'd100, 1'b1);
    step(8'd200, 1'b1);
    for (int i = 1; i <= 1100; i++) begin
      step(8'd100, 1'b1);
      if (timeout === 1'b1) begin
        n_tmo++;
        if (first_tmo == 0) first_tmo = i;
      end
    end
    checks++; if (first_tmo != 1000) begin errors++; $display("FAIL spike_tmo_at: got %0d expected 1000", first_tmo); end
    checks++; if (n_tmo != 1) begin errors++; $display("FAIL spike_tmo_count: got %0d expected 1", n_tmo); end
    checks++; if (q_per.size() != 0) begin errors++; $display("FAIL spike_strobes: got %0d expected 0", q_per.size()); end
  endtask

  task automatic test_timeout_hold();
    int first_tmo = 0;
    do_reset();
    drive_tri(10, 4, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hold_locked_pre: got %0b expected 1", locked); end
    for (int i = 1; i <= 1100; i++) begin
      step(8'd100, 1'b1);
      if (timeout === 1'b1 && first_tmo == 0) first_tmo = i;
    end
    checks++; if (first_tmo != 921) begin errors++; $display("FAIL hold_tmo_at: got %0d expected 921", first_tmo); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hold_locked_post: got %0b expected 0", locked); end
    checks++; if (period !== (AVG ? 32'd0 : 32'd80)) begin errors++; $display("FAIL hold_period: got %0d expected %0d", period, AVG ? 0 : 80); end
  endtask

  task automatic test_period_change();
    int exp_p[$];
    bit exp_l[$];
    do_reset();
    drive_tri(10, 7, 1'b0);
    drive_tri(15, 5, 1'b0);
    if (AVG) begin
      exp_p = '{80, 80, 80, 90, 100, 110, 120};
      exp_l = '{1, 1, 1, 0, 1, 1, 1};
    end else begin
      exp_p = '{80, 80, 80, 80, 80, 80, 120, 120, 120, 120};
      exp_l = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    end
    checks++; if (q_per.size() != exp_p.size()) begin errors++; $display("FAIL chg_count: got %0d expected %0d", q_per.size(), exp_p.size()); end
    for (int i = 0; i < exp_p.size() && i < q_per.size(); i++) begin
      checks++; if (q_per[i] != exp_p[i]) begin errors++; $display("FAIL chg_period[%0d]: got %0d expected %0d", i, q_per[i], exp_p[i]); end
      checks++; if (q_lck[i] != exp_l[i]) begin errors++; $display("FAIL chg_locked[%0d]: got %0b expected %0b", i, q_lck[i], exp_l[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int first_n = -1;
    do_reset();
    drive_tri(10, 4, 1'b0);
    for (int h = 0; h < 10; h++) step(8'd192, 1'b1);
    for (int h = 0; h < 5; h++) step(8'd255, 1'b1);
    reset_n = 1'b0;
    step(8'd255, 1'b1);
    reset_n = 1'b1;
    checks++; if (period !== 32'd0) begin errors++; $display("FAIL mid_period: got %0d expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", period_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked: got %0b expected 0", locked); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL mid_timeout: got %0b expected 0", timeout); end
    clear_q();
    for (int h = 0; h < 4; h++) step(8'd255, 1'b1);
    for (int h = 0; h < 10; h++) step(8'd255, 1'b1);
    for (int l = 3; l < 8; l++)
      for (int h = 0; h < 10; h++) step(lv[l], 1'b1);
    for (int n = 0; n < 6; n++) begin
      drive_tri(10, 1, 1'b0);
      if (first_n < 0 && q_per.size() > 0) first_n = n;
    end
    checks++; if (first_n != (AVG ? 4 : 1)) begin errors++; $display("FAIL mid_first_strobe: got %0d expected %0d", first_n, AVG ? 4 : 1); end
    checks++; if (q_per.size() == 0 || q_per[0] != 80) begin errors++; $display("FAIL mid_period_after: got %0d expected 80", (q_per.size() > 0) ? q_per[0] : -1); end
    checks++; if (q_lck.size() == 0 || q_lck[0] != AVG) begin errors++; $display("FAIL mid_locked_after: got %0d expected %0b", (q_lck.size() > 0) ? int'(q_lck[0]) : -1, AVG); end
  endtask

  initial begin
    lv[0] = 8'd192; lv[1] = 8'd255; lv[2] = 8'd255; lv[3] = 8'd192;
    lv[4] = 8'd128; lv[5] = 8'd64;  lv[6] = 8'd64;  lv[7] = 8'd128;
    reset_n   = 1'b0;
    sample    = 8'd0;
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_triangle();
    test_half_rate();
    test_square();
    test_glitch();
    test_spike_timeout();
    test_timeout_hold();
    test_period_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
